alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter XLEN, default 64: operand/result width, fixed to the shared ALU datapath width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  XLEN each  requester 0 operands.
REQ-007 req0_op  input  4  requester 0 ALU control code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same directions and widths as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  registered result available.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_id  output  1  requester index owning the current result.
REQ-012 rsp_result  output  XLEN  ALU result.
REQ-013 rsp_zero  output  1  rsp_result equals zero.

Function
REQ-014 Block SHALL contain one ALU datapath implementing the REQ-007 codes, shared by both requesters; shift amount = b[5:0]; SRA sign-extends a; codes 8-15 yield result 0, zero 1.
REQ-015 FSM states SHALL be IDLE, EXEC, DONE.
REQ-016 IDLE: if any reqN_valid, grant one requester, pulse its reqN_ready for that cycle, latch its a/b/op and index, go to EXEC; else stay.
REQ-017 EXEC: SHALL compute the ALU on latched operands, register result/zero/id, assert rsp_valid, go to DONE (exactly one cycle).
REQ-018 DONE: rsp_valid, rsp_id, rsp_result, rsp_zero SHALL hold stable until rsp_valid&&rsp_ready; on that edge deassert rsp_valid and go to IDLE.
REQ-019 Latency: handshake on cycle N SHALL give rsp_valid high from cycle N+2; next grant no earlier than the cycle after the response handshake.
REQ-020 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-021 Arbitration (default): round-robin; pointer names the preferred requester, moves to the other index after every grant; a lone valid requester is granted regardless of pointer.
REQ-022 Requesters SHALL hold valid and operands stable until ready; arbiter stores nothing for ungranted requests.
REQ-023 rsp_ready low indefinitely SHALL stall the FSM in DONE with no new grants.
REQ-024 Counter accepted_cnt (internal, 32-bit, wraps 0xFFFFFFFF->0) SHALL increment on each request handshake.

Reset
REQ-025 While rst high: state IDLE, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_zero 0, req0_ready 0, req1_ready 0, RR pointer 0, latched operands 0, accepted_cnt 0.
REQ-026 rst asserted in EXEC or DONE SHALL discard the in-flight operation with no response emitted.

Configuration
REQ-027 Macro ALU_ARBITER_FIXED_PRIO_EN: defined -> requester 0 always wins when both valid, RR pointer removed; undefined -> round-robin per REQ-021.

Verification
REQ-028 Reset then req0 ADD a=5 b=7 -> req0_ready pulse cycle N, rsp_valid cycle N+2, rsp_id 0, rsp_result 12, rsp_zero 0.
REQ-029 req1 SUB a=9 b=9 -> rsp_result 0, rsp_zero 1, rsp_id 1.
REQ-030 Both valid continuously, rsp_ready=1 -> grants 0,1,0,1 (FIXED_PRIO_EN defined: 0,0,0,0).
REQ-031 req0 SRA a=0x8000000000000000 b=63 -> rsp_result 0xFFFFFFFFFFFFFFFF; rsp_ready low 5 cycles -> outputs stable, req1_ready stays 0.
REQ-032 rst pulsed in EXEC -> rsp_valid never rises; all outputs at reset values; next request served normally.
REQ-033 req0 op 4'b1111 a=3 b=4 -> rsp_result 0, rsp_zero 1.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU: IDLE grants, EXEC computes, DONE holds the result until taken.
// Define ALU_ARBITER_FIXED_PRIO_EN for fixed priority to requester 0; the default build uses round-robin.
module alu_arbiter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [3:0]      req0_op,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [3:0]      req1_op,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,
    output logic [1:0]      dbg_state_o,
    output logic [31:0]     dbg_accepted_cnt_o
);
    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   a_q, b_q;
    logic [3:0]        op_q;
    logic              id_q;
    logic              rsp_valid_q, rsp_id_q, rsp_zero_q;
    logic [XLEN-1:0]   rsp_result_q;
    logic [31:0]       accepted_cnt_q;
    logic              grant_id;
    logic              accept;
    logic [XLEN-1:0]   alu_res;
    logic [5:0]        shamt;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
    always_comb begin
        grant_id = ~req0_valid;
    end
`else
    logic ptr_q;

    // Pointer only decides ties; a lone requester always wins.
    always_comb begin
        if (req0_valid && req1_valid) grant_id = ptr_q;
        else                          grant_id = ~req0_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         ptr_q <= 1'b0;
        else if (accept) ptr_q <= ~grant_id;
    end
`endif

    assign accept = (state_q == S_IDLE) && (req0_valid || req1_valid) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = accept && !grant_id;
        req1_ready  = accept && grant_id;
        dbg_state_o = state_q;
    end

    assign shamt = b_q[5:0];

    always_comb begin
        alu_res = '0;
        case (op_q)
            4'd0:    alu_res = a_q + b_q;
            4'd1:    alu_res = a_q - b_q;
            4'd2:    alu_res = a_q & b_q;
            4'd3:    alu_res = a_q | b_q;
            4'd4:    alu_res = a_q ^ b_q;
            4'd5:    alu_res = a_q << shamt;
            4'd6:    alu_res = a_q >> shamt;
            4'd7:    alu_res = $signed(a_q) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q            <= '0;
            b_q            <= '0;
            op_q           <= '0;
            id_q           <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_result_q   <= '0;
            rsp_zero_q     <= 1'b0;
            accepted_cnt_q <= '0;
        end else begin
            if (accept) begin
                a_q            <= grant_id ? req1_a : req0_a;
                b_q            <= grant_id ? req1_b : req0_b;
                op_q           <= grant_id ? req1_op : req0_op;
                id_q           <= grant_id;
                accepted_cnt_q <= accepted_cnt_q + 32'd1;
            end
            if (state_q == S_EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_id_q     <= id_q;
                rsp_result_q <= alu_res;
                rsp_zero_q   <= (alu_res == '0);
            end else if (state_q == S_DONE && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid          = rsp_valid_q;
    assign rsp_id             = rsp_id_q;
    assign rsp_result         = rsp_result_q;
    assign rsp_zero           = rsp_zero_q;
    assign dbg_accepted_cnt_o = accepted_cnt_q;
endmodule
